// File: rtl/lsu_ctrl.sv
// Load/store unit controller: checks and formats RV32I load/store requests,
// runs one word-bus access per request, and hands back a single response.
module lsu_ctrl #(
    parameter int unsigned TO_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [1:0]  resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_F3    = 2'b10;
    localparam logic [1:0] ERR_TO    = 2'b11;
    localparam logic [31:0] TO_LAST  = (TO_CYCLES == 0) ? 32'd0 : 32'(TO_CYCLES - 1);
    localparam logic        TO_EN    = (TO_CYCLES != 0);

    state_t      state_reg, state_next;
    logic        we_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] cnt_reg, cnt_next;
    logic [31:0] resp_data_reg, resp_data_next;
    logic [1:0]  resp_err_reg, resp_err_next;
    logic        latch_req;

    logic        illegal_f3;
    logic        misaligned;
    logic [7:0]  rd_lane [4];
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;

    // Request checks are made on the live inputs so errors respond one cycle after accept.
    always_comb begin
        if (req_we)
            illegal_f3 = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
        else
            illegal_f3 = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lanes
            assign rd_lane[gi] = mem_rdata[8*gi +: 8];
            // Word stores pass straight through; half and byte stores replicate the low bits.
            assign mem_wdata[8*gi +: 8] = funct3_reg[1] ? wdata_reg[8*gi +: 8] :
                                          funct3_reg[0] ? wdata_reg[8*(gi%2) +: 8] :
                                                          wdata_reg[7:0];
        end
    endgenerate

    always_comb begin
        ld_byte = rd_lane[addr_reg[1:0]];
        ld_half = addr_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_reg)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_data = {24'd0, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_data = {16'd0, ld_half};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        mem_be = 4'b0000;
        if (state_reg == BUS) begin
            if (!we_reg)
                mem_be = 4'b1111;
            else begin
                case (funct3_reg[1:0])
                    2'b00:   mem_be = 4'b0001 << addr_reg[1:0];
                    2'b01:   mem_be = 4'b0011 << addr_reg[1:0];
                    default: mem_be = 4'b1111;
                endcase
            end
        end
    end

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign mem_req    = (state_reg == BUS);
    assign mem_we     = (state_reg == BUS) && we_reg;
    assign mem_addr   = {addr_reg[31:2], 2'b00};
    assign resp_data  = resp_data_reg;
    assign resp_err   = resp_err_reg;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        resp_data_next = resp_data_reg;
        resp_err_next  = resp_err_reg;
        latch_req      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    latch_req = 1'b1;
                    if (illegal_f3) begin
                        state_next     = RESP;
                        resp_err_next  = ERR_F3;
                        resp_data_next = 32'd0;
                    end else if (misaligned) begin
                        state_next     = RESP;
                        resp_err_next  = ERR_ALIGN;
                        resp_data_next = 32'd0;
                    end else begin
                        state_next = BUS;
                        cnt_next   = 32'd0;
                    end
                end
            end
            BUS: begin
                // An ack on the final wait cycle still completes the access normally.
                if (mem_ack) begin
                    state_next     = RESP;
                    resp_err_next  = ERR_OK;
                    resp_data_next = we_reg ? 32'd0 : load_data;
                end else if (TO_EN && (cnt_reg == TO_LAST)) begin
                    state_next     = RESP;
                    resp_err_next  = ERR_TO;
                    resp_data_next = 32'd0;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            RESP: begin
                if (resp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            we_reg        <= 1'b0;
            funct3_reg    <= 3'd0;
            addr_reg      <= 32'd0;
            wdata_reg     <= 32'd0;
            cnt_reg       <= 32'd0;
            resp_data_reg <= 32'd0;
            resp_err_reg  <= ERR_OK;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            resp_data_reg <= resp_data_next;
            resp_err_reg  <= resp_err_next;
            if (latch_req) begin
                we_reg     <= req_we;
                funct3_reg <= req_funct3;
                addr_reg   <= req_addr;
                wdata_reg  <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: loads, stores, error codes, timeout, backpressure and reset.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic [1:0]  resp_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    lsu_ctrl #(.TO_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Load vectors: funct3, address, bus word, expected formatted data.
    logic [2:0]  ld_f3   [7] = '{3'b000, 3'b000, 3'b001, 3'b101, 3'b001, 3'b010, 3'b100};
    logic [31:0] ld_addr [7] = '{32'h1003, 32'h1001, 32'h1002, 32'h1002, 32'h1000, 32'h1004, 32'h1002};
    logic [31:0] ld_rd   [7] = '{32'h80FF1122, 32'h80FF1122, 32'h80FF1122, 32'h80FF1122,
                                 32'h80FF1122, 32'hCAFEF00D, 32'h80FF1122};
    logic [31:0] ld_exp  [7] = '{32'hFFFFFF80, 32'h00000011, 32'hFFFF80FF, 32'h000080FF,
                                 32'h00001122, 32'hCAFEF00D, 32'h000000FF};

    // Store vectors: funct3, address, data, expected lanes and bus data.
    logic [2:0]  st_f3   [5] = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b001};
    logic [31:0] st_addr [5] = '{32'h2002, 32'h2001, 32'h2003, 32'h2004, 32'h2000};
    logic [31:0] st_wd   [5] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'h12345678, 32'h12345678, 32'h12345678};
    logic [3:0]  st_be   [5] = '{4'b1100, 4'b0010, 4'b1000, 4'b1111, 4'b0011};
    logic [31:0] st_mwd  [5] = '{32'hBEEFBEEF, 32'hEFEFEFEF, 32'h78787878, 32'h12345678, 32'h56785678};

    // Error vectors: we, funct3, address, expected code.
    logic        er_we   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0]  er_f3   [8] = '{3'b010, 3'b011, 3'b011, 3'b001, 3'b100, 3'b010, 3'b110, 3'b101};
    logic [31:0] er_addr [8] = '{32'h3001, 32'h3000, 32'h3001, 32'h3001, 32'h3000, 32'h3002, 32'h3000, 32'h3003};
    logic [1:0]  er_exp  [8] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};

    // Presents a request for one cycle; returns at the negedge of the cycle after acceptance.
    task automatic accept(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_req_we got=%b%b exp=00", mem_req, mem_we); end
        checks++; if (mem_be !== 4'b0000) begin failures++; $display("FAIL reset_mem_be got=%b exp=0000", mem_be); end
        checks++; if (resp_data !== 32'd0 || resp_err !== 2'b00) begin failures++; $display("FAIL reset_resp got=%h/%b exp=00000000/00", resp_data, resp_err); end
        $display("reset: req_ready=%b resp_valid=%b mem_req=%b", req_ready, resp_valid, mem_req);
    endtask

    task automatic test_lbu();
        accept(1'b0, 3'b100, 32'h1003, 32'h0);
        checks++; if (mem_req !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL lbu_cycle1 got=mem_req%b resp_valid%b exp=1/0", mem_req, resp_valid); end
        checks++; if (mem_addr !== 32'h1000 || mem_be !== 4'b1111 || mem_we !== 1'b0) begin failures++; $display("FAIL lbu_bus got=%h/%b/%b exp=00001000/1111/0", mem_addr, mem_be, mem_we); end
        mem_ack = 1'b1; mem_rdata = 32'h80FF1122;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++; if (resp_valid !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL lbu_resp_valid got=%b/%b exp=1/0", resp_valid, mem_req); end
        checks++; if (resp_data !== 32'h00000080 || resp_err !== 2'b00) begin failures++; $display("FAIL lbu_data got=%h/%b exp=00000080/00", resp_data, resp_err); end
        $display("lbu 0x1003: resp_data=%h err=%b", resp_data, resp_err);
        consume();
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL lbu_idle got=%b/%b exp=1/0", req_ready, resp_valid); end
    endtask

    task automatic test_stores();
        for (int i = 0; i < 5; i++) begin
            accept(1'b1, st_f3[i], st_addr[i], st_wd[i]);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== {st_addr[i][31:2], 2'b00} ||
                    mem_be !== st_be[i] || mem_wdata !== st_mwd[i]) begin
                    failures++;
                    $display("FAIL store%0d_bus_c%0d got=req%b we%b %h %b %h exp=req1 we1 %h %b %h", i, k,
                             mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                             {st_addr[i][31:2], 2'b00}, st_be[i], st_mwd[i]);
                end
                if (k == 1) begin mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF; end
                @(negedge clk);
            end
            mem_ack = 1'b0;
            checks++; if (resp_valid !== 1'b1 || resp_data !== 32'd0 || resp_err !== 2'b00) begin failures++; $display("FAIL store%0d_resp got=%b/%h/%b exp=1/00000000/00", i, resp_valid, resp_data, resp_err); end
            $display("store f3=%b addr=%h: be=%b wdata=%h resp_err=%b", st_f3[i], st_addr[i], st_be[i], st_mwd[i], resp_err);
            consume();
        end
    endtask

    task automatic test_errors();
        for (int i = 0; i < 8; i++) begin
            accept(er_we[i], er_f3[i], er_addr[i], 32'h5555AAAA);
            checks++; if (mem_req !== 1'b0 || resp_valid !== 1'b1) begin failures++; $display("FAIL err%0d_path got=mem_req%b resp_valid%b exp=0/1", i, mem_req, resp_valid); end
            checks++; if (resp_err !== er_exp[i] || resp_data !== 32'd0) begin failures++; $display("FAIL err%0d_code got=%b/%h exp=%b/00000000", i, resp_err, resp_data, er_exp[i]); end
            $display("error we=%b f3=%b addr=%h: err=%b", er_we[i], er_f3[i], er_addr[i], resp_err);
            consume();
        end
    endtask

    task automatic test_loads();
        for (int i = 0; i < 7; i++) begin
            accept(1'b0, ld_f3[i], ld_addr[i], 32'h0);
            mem_ack = 1'b1; mem_rdata = ld_rd[i];
            @(negedge clk);
            mem_ack = 1'b0;
            checks++; if (resp_valid !== 1'b1 || resp_data !== ld_exp[i] || resp_err !== 2'b00) begin failures++; $display("FAIL load%0d got=%b/%h/%b exp=1/%h/00", i, resp_valid, resp_data, resp_err, ld_exp[i]); end
            $display("load f3=%b addr=%h rdata=%h: resp_data=%h", ld_f3[i], ld_addr[i], ld_rd[i], resp_data);
            consume();
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        accept(1'b0, 3'b010, 32'h4000, 32'h0);
        for (int i = 0; i < 20 && resp_valid !== 1'b1; i++) begin
            if (mem_req === 1'b1) n++;
            @(negedge clk);
        end
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL timeout_wait got=resp_valid%b exp=1", resp_valid); end
        checks++; if (n != 4 || mem_req !== 1'b0) begin failures++; $display("FAIL timeout_req_cycles got=%0d/%b exp=4/0", n, mem_req); end
        checks++; if (resp_err !== 2'b11 || resp_data !== 32'd0) begin failures++; $display("FAIL timeout_code got=%b/%h exp=11/00000000", resp_err, resp_data); end
        $display("timeout: mem_req cycles=%0d err=%b", n, resp_err);
        consume();
    endtask

    task automatic test_timeout_ack();
        accept(1'b0, 3'b010, 32'h4008, 32'h0);
        for (int i = 0; i < 3; i++) @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL to_ack_req4 got=%b exp=1", mem_req); end
        mem_ack = 1'b1; mem_rdata = 32'h13579BDF;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_err !== 2'b00 || resp_data !== 32'h13579BDF) begin failures++; $display("FAIL to_ack_resp got=%b/%b/%h exp=1/00/13579bdf", resp_valid, resp_err, resp_data); end
        $display("ack on last wait cycle: err=%b data=%h", resp_err, resp_data);
        consume();
    endtask

    task automatic test_back_pressure();
        accept(1'b0, 3'b010, 32'h5000, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'hA1B2C3D4;
        @(negedge clk);
        // A competing request and a stray ack must both be ignored while the response waits.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h5100; mem_rdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== 32'hA1B2C3D4 || resp_err !== 2'b00 ||
                req_ready !== 1'b0 || mem_req !== 1'b0) begin
                failures++;
                $display("FAIL hold_c%0d got=%b/%h/%b rdy%b req%b exp=1/a1b2c3d4/00 rdy0 req0", i,
                         resp_valid, resp_data, resp_err, req_ready, mem_req);
            end
            @(negedge clk);
        end
        req_valid = 1'b0; mem_ack = 1'b0;
        $display("backpressure: resp_data=%h held", resp_data);
        consume();
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL hold_release got=%b/%b/%b exp=1/0/0", req_ready, resp_valid, mem_req); end
    endtask

    task automatic test_reset_mid_bus();
        accept(1'b1, 3'b010, 32'h6000, 32'hFFFF0000);
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rst_bus_pre got=%b exp=1", mem_req); end
        #2 rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'b0000 || req_ready !== 1'b1) begin failures++; $display("FAIL rst_async got=req%b we%b be%b rdy%b exp=req0 we0 be0000 rdy1", mem_req, mem_we, mem_be, req_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_req !== 1'b0 || resp_data !== 32'd0) begin failures++; $display("FAIL rst_after got=%b/%b/%b/%h exp=1/0/0/00000000", req_ready, resp_valid, mem_req, resp_data); end
        accept(1'b0, 3'b000, 32'h1003, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h80FF1122;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hFFFFFF80) begin failures++; $display("FAIL rst_recover got=%b/%h exp=1/ffffff80", resp_valid, resp_data); end
        $display("reset mid-bus: recovered lb data=%h", resp_data);
        consume();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0;
        req_wdata = 32'd0; resp_ready = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_lbu();
        test_stores();
        test_errors();
        test_loads();
        test_timeout();
        test_timeout_ack();
        test_back_pressure();
        test_reset_mid_bus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TO_CYCLES, default 64, bus-wait timeout in cycles; value 0 disables the timeout.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  core issues a load/store.
REQ-005 req_ready  output  1  controller can accept a request.
REQ-006 req_we  input  1  1=store, 0=load.
REQ-007 req_funct3  input  3  RV32I load/store funct3.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data (rs2).
REQ-010 resp_valid  output  1  response available.
REQ-011 resp_ready  input  1  core consumes response.
REQ-012 resp_data  output  32  formatted load data (0 for stores and errors).
REQ-013 resp_err  output  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout.
REQ-014 mem_req  output  1  bus request, held until mem_ack.
REQ-015 mem_we  output  1  bus write enable.
REQ-016 mem_addr  output  32  word address, {req_addr[31:2],2'b00}.
REQ-017 mem_be  output  4  byte lane enables.
REQ-018 mem_wdata  output  32  lane-replicated store data.
REQ-019 mem_ack  input  1  bus completion; mem_rdata valid same cycle.
REQ-020 mem_rdata  input  32  bus read word.

Function
REQ-021 FSM states IDLE, BUS, RESP; req_ready=1 only in IDLE.
REQ-022 IDLE: on req_valid, latch we/funct3/addr/wdata; if error detected go RESP with code, else go BUS.
REQ-023 Legal funct3: loads 000,001,010,100,101; stores 000,001,010; anything else -> err 10, no bus access.
REQ-024 Misaligned: half (x01) with addr[0]=1, word (010) with addr[1:0]!=0 -> err 01, no bus access; illegal funct3 takes priority.
REQ-025 BUS: mem_req=1 and mem_we/addr/be/wdata driven from latched request and held stable until mem_ack.
REQ-026 Store lanes: sb be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}; sh be=4'b0011<<addr[1:0], wdata={2{wdata[15:0]}}; sw be=4'b1111, wdata unmodified; loads drive be=4'b1111.
REQ-027 Load format on mem_ack: lb/lbu select byte addr[1:0], lh/lhu select half addr[1], sign- or zero-extended per funct3; lw passes word.
REQ-028 BUS + mem_ack: register resp_data (0 for store), err 00, go RESP next cycle.
REQ-029 Wait counter clears on BUS entry and increments each BUS cycle without mem_ack; if TO_CYCLES!=0 and counter reaches TO_CYCLES-1 without ack, drop mem_req, err 11, resp_data 0, go RESP.
REQ-030 mem_ack on the timeout cycle wins: response is ok with data.
REQ-031 RESP: resp_valid=1, resp_data/resp_err stable until resp_ready; on resp_valid&&resp_ready go IDLE.
REQ-032 Minimum latency: accept cycle N, mem_req cycle N+1, ack at N+1 -> resp_valid cycle N+2; error path resp_valid cycle N+1.
REQ-033 mem_ack outside BUS is ignored; no new request accepted until response consumed (one outstanding).

Reset
REQ-034 rst asserted at any time forces IDLE immediately: req_ready=1, resp_valid=0, mem_req=0, mem_we=0, mem_be=0, resp_data=0, resp_err=00, counter=0; an in-flight bus access is abandoned.

Verification
REQ-035 lbu addr=0x1003, mem_rdata=0x80FF_1122, ack first BUS cycle -> resp_data=0x0000_0080, err 00, resp_valid 2 cycles after accept.
REQ-036 sh addr=0x2002 wdata=0xDEAD_BEEF -> mem_addr=0x2000, mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_we=1; resp_data=0.
REQ-037 lw addr=0x3001 -> err 01 next cycle, mem_req never asserted; funct3=011 load -> err 10.
REQ-038 TO_CYCLES=4, no ack -> mem_req high 4 cycles then low, err 11; repeat with ack on 4th cycle -> err 00.
REQ-039 resp_ready held low 5 cycles -> resp_valid/data stable, req_ready=0; rst asserted mid-BUS -> mem_req=0 same cycle, IDLE after release.
